mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-mapped responder: word RAM plus a small I/O block (LEDs, switches,
// free-running cycle counter, one-shot timer) at the top 16 addresses.
module mem_responder #(
  parameter int WIDTH     = 16,
  parameter int RAM_WORDS = 1024,
  parameter int SW_BITS   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mem_addr,
  input  logic [WIDTH-1:0]   writedata,
  input  logic               MEM_WR_S,
  output logic [WIDTH-1:0]   mem_out,
  input  logic [SW_BITS-1:0] switches,
  output logic [SW_BITS-1:0] leds
);

  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [3:0] IO_LED    = 4'h0;
  localparam logic [3:0] IO_SW     = 4'h1;
  localparam logic [3:0] IO_CNT    = 4'h2;
  localparam logic [3:0] IO_TIMER  = 4'h3;
  localparam logic [3:0] IO_STATUS = 4'h4;

  logic [WIDTH-1:0]   ram [RAM_WORDS];

  logic [WIDTH-1:0]   mem_out_q, mem_out_d;
  logic [SW_BITS-1:0] led_q, led_d;
  logic [SW_BITS-1:0] sw_meta_q, sw_sync_q;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   timer_q, timer_d;
  logic               expired_q, expired_d;

  logic               io_sel;
  logic [3:0]         io_reg;
  logic [IDX_W-1:0]   ram_idx;
  logic               wr_en;
  logic               ram_we;
  logic               timer_fire;

  assign io_sel  = &mem_addr[WIDTH-1:4];
  assign io_reg  = mem_addr[3:0];
  assign ram_idx = mem_addr[IDX_W-1:0];
  // Writes are dropped while reset is held.
  assign wr_en   = MEM_WR_S & reset;
  assign ram_we  = wr_en & ~io_sel;

  always_comb begin
    led_d      = led_q;
    cnt_d      = cnt_q + ONE;
    timer_d    = timer_q;
    expired_d  = expired_q;
    timer_fire = 1'b0;

    if (wr_en && io_sel && io_reg == IO_LED) led_d = writedata[SW_BITS-1:0];
    if (wr_en && io_sel && io_reg == IO_CNT) cnt_d = writedata;

    if (wr_en && io_sel && io_reg == IO_TIMER) begin
      timer_d = writedata;
    end else if (timer_q != '0) begin
      timer_d    = timer_q - ONE;
      timer_fire = (timer_q == ONE);
    end

    // Set has priority over a coincident clear.
    if (wr_en && io_sel && io_reg == IO_STATUS) expired_d = 1'b0;
    if (timer_fire) expired_d = 1'b1;
  end

  // Read data reflects post-edge register state, which also gives write-first.
  always_comb begin
    mem_out_d = '0;
    if (!io_sel) begin
      mem_out_d = ram_we ? writedata : ram[ram_idx];
    end else begin
      case (io_reg)
        IO_LED:    mem_out_d = {{(WIDTH-SW_BITS){1'b0}}, led_d};
        IO_SW:     mem_out_d = {{(WIDTH-SW_BITS){1'b0}}, sw_meta_q};
        IO_CNT:    mem_out_d = cnt_d;
        IO_TIMER:  mem_out_d = timer_d;
        IO_STATUS: mem_out_d = {{(WIDTH-1){1'b0}}, expired_d};
        default:   mem_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_out_q <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      mem_out_q <= mem_out_d;
      led_q     <= led_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      expired_q <= expired_d;
    end
  end

  assign mem_out = mem_out_q;
  assign leds    = led_q;

  // Second synchronizer stage is what the read mux sees after the edge.
  logic unused_sync;
  assign unused_sync = ^sw_sync_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM, aliasing, LED/switch I/O, counter,
// timer/expired behaviour and reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] writedata;
  logic        MEM_WR_S;
  logic [15:0] mem_out;
  logic [9:0]  switches;
  logic [9:0]  leds;

  int checks = 0;
  int errors = 0;

  mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .writedata (writedata),
    .MEM_WR_S  (MEM_WR_S),
    .mem_out   (mem_out),
    .switches  (switches),
    .leds      (leds)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr = a; writedata = d; MEM_WR_S = 1'b1;
    step();
    MEM_WR_S = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    mem_addr = a; MEM_WR_S = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; mem_addr = 16'h0; writedata = 16'h0; MEM_WR_S = 1'b0;
    switches = 10'h2A5;

    // Writes during reset must be ignored.
    wr(16'hFFF0, 16'hFFFF);
    step();
    chk("reset_mem_out", mem_out, 0);
    chk("reset_leds", leds, 0);

    reset = 1'b1;
    rd(16'hFFF2);
    chk("cnt_first_edge", mem_out, 1);

    wr(16'h0005, 16'h1234);
    chk("ram_write_first", mem_out, 16'h1234);
    rd(16'h0005);
    chk("ram_read", mem_out, 16'h1234);
    rd(16'h0405);
    chk("ram_alias", mem_out, 16'h1234);

    wr(16'hFFF0, 16'h03FF);
    chk("led_write_leds", leds, 10'h3FF);
    chk("led_write_first", mem_out, 16'h03FF);
    rd(16'hFFF0);
    chk("led_read", mem_out, 16'h03FF);
    wr(16'hFFF1, 16'hABCD);
    chk("sw_write_leds", leds, 10'h3FF);
    chk("sw_write_reads_sw", mem_out, 16'h02A5);
    rd(16'h0005);
    chk("sw_write_ram_kept", mem_out, 16'h1234);

    switches = 10'h155;
    rd(16'hFFF1);
    chk("sw_sync_stage1", mem_out, 16'h02A5);
    rd(16'hFFF1);
    chk("sw_sync_stage2", mem_out, 16'h0155);

    wr(16'hFFF7, 16'h7777);
    chk("unmapped_write", mem_out, 0);
    rd(16'hFFF7);
    chk("unmapped_read", mem_out, 0);
    chk("unmapped_leds", leds, 10'h3FF);

    wr(16'hFFF2, 16'hFFFE);
    chk("cnt_write_first", mem_out, 16'hFFFE);
    rd(16'hFFF2);
    chk("cnt_seq0", mem_out, 16'hFFFF);
    rd(16'hFFF2);
    chk("cnt_wrap", mem_out, 16'h0000);
    rd(16'hFFF2);
    chk("cnt_seq2", mem_out, 16'h0001);

    wr(16'hFFF3, 16'h0003);
    chk("tmr_load", mem_out, 3);
    rd(16'hFFF3);
    chk("tmr_2", mem_out, 2);
    rd(16'hFFF3);
    chk("tmr_1", mem_out, 1);
    rd(16'hFFF4);
    chk("tmr_expired_at_0", mem_out, 1);
    rd(16'hFFF3);
    chk("tmr_hold_0", mem_out, 0);
    rd(16'hFFF4);
    chk("tmr_expired_sticky", mem_out, 1);
    wr(16'hFFF4, 16'h0000);
    chk("status_clear_wf", mem_out, 0);
    rd(16'hFFF4);
    chk("status_cleared", mem_out, 0);

    wr(16'hFFF3, 16'h0002);
    rd(16'hFFF3);
    chk("tmr_race_1", mem_out, 1);
    wr(16'hFFF4, 16'h0000);
    chk("race_set_wins_wf", mem_out, 1);
    rd(16'hFFF4);
    chk("race_set_wins", mem_out, 1);
    wr(16'hFFF4, 16'hFFFF);
    rd(16'hFFF4);
    chk("status_clear2", mem_out, 0);

    wr(16'hFFF3, 16'h0000);
    rd(16'hFFF4);
    chk("load0_no_expire", mem_out, 0);

    wr(16'hFFF3, 16'h0005);
    chk("tmr_load5", mem_out, 5);
    reset = 1'b0;
    step();
    chk("midreset_mem_out", mem_out, 0);
    chk("midreset_leds", leds, 0);
    reset = 1'b1;
    rd(16'hFFF3);
    chk("midreset_timer", mem_out, 0);
    rd(16'hFFF4);
    chk("midreset_expired", mem_out, 0);
    rd(16'hFFF0);
    chk("midreset_led_reg", mem_out, 0);
    rd(16'h0005);
    chk("midreset_ram_kept", mem_out, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
